// File: rtl/v1_pulse_capture_ctrl_if.sv
// rtl/v1_pulse_capture_ctrl_if.sv - event record valid/ready channel of the pulse capture controller
interface v1_pulse_capture_ctrl_if #(
    parameter int DATA_W = 17,
    parameter int TS_W   = 32,
    parameter int WID_W  = 8
);
    logic                     ev_valid;
    logic                     ev_ready;
    logic signed [DATA_W-1:0] ev_amp;
    logic [TS_W-1:0]          ev_ts;
    logic [WID_W-1:0]         ev_width;

    modport master (output ev_valid, ev_amp, ev_ts, ev_width, input ev_ready);
    modport slave  (input ev_valid, ev_amp, ev_ts, ev_width, output ev_ready);
endinterface

// File: rtl/v1_pulse_capture_ctrl.sv
// rtl/v1_pulse_capture_ctrl.sv - threshold-armed pulse peak/width capture; PILEUP_REJECT_EN adds a width limit
module v1_pulse_capture_ctrl #(
    parameter int DATA_W    = 17,
    parameter int TS_W      = 32,
    parameter int WID_W     = 8,
    parameter int DEAD_W    = 8,
    parameter int MAX_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic [DEAD_W-1:0]        dead_time,
    v1_pulse_capture_ctrl_if.master  ev,
    output logic                     busy,
    output logic [15:0]              lost_cnt,
    output logic [15:0]              pileup_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TRACK, S_EMIT, S_DEAD} state_t;

    localparam logic [WID_W-1:0] WID_SAT = '1;

    state_t                   state;
    logic [TS_W-1:0]          ts;
    logic [TS_W-1:0]          peak_ts;
    logic signed [DATA_W-1:0] peak;
    logic [WID_W-1:0]         width;
    logic [DEAD_W-1:0]        cnt;
    logic                     prev_above;
    logic                     above;
    logic                     slot_free;

    assign above     = sample > threshold;
    // The slot counts as free when the held record is being accepted this very cycle.
    assign slot_free = !ev.ev_valid || ev.ev_ready;
    assign busy      = (state != S_IDLE) && (state != S_WAIT);

`ifndef PILEUP_REJECT_EN
    assign pileup_cnt = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ts          <= '0;
            peak_ts     <= '0;
            peak        <= '0;
            width       <= '0;
            cnt         <= '0;
            prev_above  <= 1'b0;
            lost_cnt    <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_amp   <= '0;
            ev.ev_ts    <= '0;
            ev.ev_width <= '0;
`ifdef PILEUP_REJECT_EN
            pileup_cnt  <= '0;
`endif
        end else begin
            ts         <= ts + 1'b1;
            prev_above <= above;
            if (ev.ev_valid && ev.ev_ready)
                ev.ev_valid <= 1'b0;

            if (!enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: state <= S_WAIT;
                    S_WAIT: begin
                        if (above && !prev_above) begin
                            state   <= S_TRACK;
                            peak    <= sample;
                            peak_ts <= ts;
                            width   <= WID_W'(1);
                        end
                    end
                    S_TRACK: begin
                        if (!above) begin
                            state <= S_EMIT;
                        end else begin
                            if (width != WID_SAT)
                                width <= width + 1'b1;
                            // Strict compare keeps the timestamp of the first maximum.
                            if (sample > peak) begin
                                peak    <= sample;
                                peak_ts <= ts;
                            end
`ifdef PILEUP_REJECT_EN
                            if (int'(width) + 1 >= MAX_WIDTH) begin
                                if (pileup_cnt != 16'hFFFF)
                                    pileup_cnt <= pileup_cnt + 1'b1;
                                cnt   <= dead_time;
                                state <= (dead_time == '0) ? S_WAIT : S_DEAD;
                            end
`endif
                        end
                    end
                    S_EMIT: begin
                        if (slot_free) begin
                            ev.ev_valid <= 1'b1;
                            ev.ev_amp   <= peak;
                            ev.ev_ts    <= peak_ts;
                            ev.ev_width <= width;
                        end else if (lost_cnt != 16'hFFFF) begin
                            lost_cnt <= lost_cnt + 1'b1;
                        end
                        cnt   <= dead_time;
                        state <= (dead_time == '0) ? S_WAIT : S_DEAD;
                    end
                    S_DEAD: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == DEAD_W'(1))
                            state <= S_WAIT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_v1_pulse_capture_ctrl.sv
// tb/tb_v1_pulse_capture_ctrl.sv - directed and randomized pulse tests against a pulse-level reference
module tb_v1_pulse_capture_ctrl;
    localparam int DATA_W = 17;

    typedef struct {
        longint amp;
        longint ts;
        longint wid;
    } rec_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] threshold;
    logic [7:0]               dead_time;
    logic                     busy;
    logic [15:0]              lost_cnt;
    logic [15:0]              pileup_cnt;

    v1_pulse_capture_ctrl_if evif ();

    v1_pulse_capture_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sample     (sample),
        .threshold  (threshold),
        .dead_time  (dead_time),
        .ev         (evif),
        .busy       (busy),
        .lost_cnt   (lost_cnt),
        .pileup_cnt (pileup_cnt)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint mts;
    longint last_tag;
    int     pv [0:127];
    rec_t   exp_q [$];

    logic                     held_q;
    logic signed [DATA_W-1:0] h_amp;
    logic [31:0]              h_ts;
    logic [7:0]               h_wid;

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference timestamp: the cycle count since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) mts <= 0;
        else        mts <= mts + 1;
    end

    // Scoreboard on accepted records plus stability of held records.
    always @(negedge clk) begin
        if (!reset) begin
            held_q <= 1'b0;
        end else begin
            if (held_q) begin
                check_val("hold_valid", longint'(evif.ev_valid), 1);
                check_val("hold_amp", longint'(evif.ev_amp), longint'(h_amp));
                check_val("hold_ts", longint'(evif.ev_ts), longint'(h_ts));
                check_val("hold_wid", longint'(evif.ev_width), longint'(h_wid));
            end
            if (evif.ev_valid && evif.ev_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_event", 1, 0);
                end else begin
                    check_val("ev_amp", longint'(evif.ev_amp), exp_q[0].amp);
                    check_val("ev_ts", longint'(evif.ev_ts), exp_q[0].ts);
                    check_val("ev_width", longint'(evif.ev_width), exp_q[0].wid);
                    exp_q.delete(0);
                end
            end
            held_q <= evif.ev_valid && !evif.ev_ready;
            h_amp  <= evif.ev_amp;
            h_ts   <= evif.ev_ts;
            h_wid  <= evif.ev_width;
        end
    end

    task automatic drive(input int v);
        @(posedge clk);
        #1;
        sample   = DATA_W'(v);
        last_tag = mts;
    endtask

    task automatic drive_n(input int v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    // Drives pv[0..n-1] as the above-threshold part of a pulse; the record follows from max/first/count.
    task automatic pulse(input int n, input bit want);
        rec_t r;
        r.amp = -1000000;
        r.ts  = 0;
        for (int i = 0; i < n; i++) begin
            drive(pv[i]);
            if (pv[i] > r.amp) begin
                r.amp = pv[i];
                r.ts  = last_tag;
            end
        end
        r.wid = (n > 255) ? 255 : n;
        if (want) exp_q.push_back(r);
    endtask

    task automatic set_thr(input int t);
        drive(-60000);
        threshold = DATA_W'(t);
        drive_n(-60000, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int thr;
        int dt;
        int n;
        int g;
        reset       = 1'b0;
        enable      = 1'b1;
        evif.ev_ready = 1'b1;
        sample      = '0;
        threshold   = DATA_W'(100);
        dead_time   = 8'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", longint'(evif.ev_valid), 0);
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_lost", longint'(lost_cnt), 0);
        check_val("rst_pileup", longint'(pileup_cnt), 0);
        check_val("rst_amp", longint'(evif.ev_amp), 0);
        check_val("rst_ts", longint'(evif.ev_ts), 0);
        check_val("rst_wid", longint'(evif.ev_width), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single pulse at ts 10..14.
        do drive(0); while (last_tag < 10);
        pv[0] = 150; pv[1] = 300; pv[2] = 250;
        pulse(3, 1);
        drive(50);
        drive(0);  @(negedge clk); check_val("single_v_t15", longint'(evif.ev_valid), 0);
        drive(0);  @(negedge clk); check_val("single_v_t16", longint'(evif.ev_valid), 1);
        check_val("single_ts", longint'(evif.ev_ts), 12);
        check_val("single_amp", longint'(evif.ev_amp), 300);
        drive(0);  @(negedge clk); check_val("single_v_t17", longint'(evif.ev_valid), 0);
        drive_n(0, 6);

        // Equal peaks keep the first one.
        pv[0] = 200; pv[1] = 200;
        pulse(2, 1);
        drive_n(0, 8);

        // Dead time: crossing 5 cycles after EMIT ignored, 12 cycles after captured.
        dead_time = 8'd10;
        drive_n(0, 4);
        pv[0] = 400; pulse(1, 1);
        drive_n(0, 6);
        pv[0] = 300; pulse(1, 0);
        drive_n(0, 20);
        pv[0] = 410; pulse(1, 1);
        drive_n(0, 13);
        pv[0] = 310; pulse(1, 1);
        drive_n(0, 15);

        // Enable drop mid-TRACK, level still high at re-enable.
        dead_time = 8'd2;
        pv[0] = 500; pv[1] = 500; pulse(2, 0);
        enable = 1'b0;
        drive_n(500, 3);
        @(negedge clk); check_val("dis_busy", longint'(busy), 0);
        enable = 1'b1;
        drive_n(500, 5);
        drive_n(0, 8);
        pv[0] = 350; pulse(1, 1);
        drive_n(0, 8);

        // Long pulse: pile-up limit or plain saturation-free width of 80.
        dead_time = 8'd3;
        for (int i = 0; i < 80; i++) pv[i] = 1000;
`ifdef PILEUP_REJECT_EN
        pulse(80, 0);
        drive_n(0, 10);
        @(negedge clk); check_val("pileup_cnt", longint'(pileup_cnt), 1);
`else
        pulse(80, 1);
        drive_n(0, 10);
        @(negedge clk); check_val("pileup_cnt", longint'(pileup_cnt), 0);
`endif
        check_val("lost_before_bp", longint'(lost_cnt), 0);

        // Backpressure: 500 held, 700 lost.
        evif.ev_ready = 1'b0;
        dead_time = 8'd4;
        drive_n(0, 3);
        pv[0] = 500; pulse(1, 1);
        drive_n(0, 10);
        pv[0] = 700; pulse(1, 0);
        drive_n(0, 8);
        @(negedge clk);
        check_val("bp_lost", longint'(lost_cnt), 1);
        check_val("bp_valid", longint'(evif.ev_valid), 1);
        check_val("bp_amp", longint'(evif.ev_amp), 500);
        evif.ev_ready = 1'b1;
        drive(0);
        drive(0); @(negedge clk); check_val("bp_drop", longint'(evif.ev_valid), 0);
        drive_n(0, 3);

        // Async reset mid-pulse with a pending record.
        evif.ev_ready = 1'b0;
        dead_time = 8'd2;
        pv[0] = 600; pulse(1, 0);
        drive_n(0, 6);
        pv[0] = 800; pv[1] = 800; pulse(2, 0);
        #3 reset = 1'b0;
        #1;
        check_val("arst_valid", longint'(evif.ev_valid), 0);
        check_val("arst_lost", longint'(lost_cnt), 0);
        check_val("arst_busy", longint'(busy), 0);
        check_val("arst_pileup", longint'(pileup_cnt), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        evif.ev_ready = 1'b1;
        drive_n(0, 5);
        pv[0] = 250; pv[1] = 260; pulse(2, 1);
        drive_n(0, 8);

        // Randomized pulses with random downstream readiness in the gaps.
        thr = int'($urandom_range(0, 4000)) - 2000;
        set_thr(thr);
        for (int k = 0; k < 40; k++) begin
            dt = int'($urandom_range(0, 6));
            dead_time = 8'(dt);
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) pv[i] = thr + 1 + int'($urandom_range(0, 7)) * 50;
            evif.ev_ready = 1'b1;
            pulse(n, 1);
            g = dt + 2 + int'($urandom_range(0, 5));
            for (int i = 0; i < g; i++) begin
                evif.ev_ready = 1'($urandom_range(0, 1));
                drive(thr - int'($urandom_range(0, 500)));
            end
        end
        evif.ev_ready = 1'b1;
        drive_n(thr - 10, 10);

        @(negedge clk);
        check_val("queue_empty", longint'(exp_q.size()), 0);
        check_val("lost_final", longint'(lost_cnt), 0);
        check_val("valid_final", longint'(evif.ev_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
